// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the display-register write arbiter and its picker.
// The round-robin build is selected with the ARB_RR_EN macro (see rr_pick4).
package reg_share_arbiter_pkg;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int IW   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   function automatic logic [NREQ-1:0] onehot4(input logic [IW-1:0] idx);
      logic [NREQ-1:0] vec;
      vec      = {NREQ{1'b0}};
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick4.sv
// Combinational winner selection for four requesters.
// ARB_RR_EN defined: scan starts at ptr; undefined: lowest index wins.
module rr_pick4
   import reg_share_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   win,
   output logic            vld
);

`ifdef ARB_RR_EN
   // Descending scan so the position closest to ptr is the last assignment.
   always_comb begin
      logic [IW-1:0] idx;
      win = {IW{1'b0}};
      vld = |req;
      idx = {IW{1'b0}};
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = ptr + IW'(i);
         if (req[idx]) begin
            win = idx;
         end else begin
            win = win;
         end
      end
   end
`else
   logic ptr_unused_s;
   assign ptr_unused_s = ^ptr;

   // Fixed priority: descending scan leaves the lowest set index.
   always_comb begin
      win = {IW{1'b0}};
      vld = |req;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win = IW'(i);
         end else begin
            win = win;
         end
      end
   end
`endif

endmodule

// File: rtl/reg_share_arbiter.sv
// Four-way write arbiter for the shared 16-bit display register (IDLE/GRANT/HOLD).
// Arbitration policy follows ARB_RR_EN inside rr_pick4.
module reg_share_arbiter
   import reg_share_arbiter_pkg::*;
#(
   parameter int HOLD_CYC = 2
)(
   input  logic              Clk,
   input  logic              Clrn,
   input  logic [NREQ-1:0]   Req,
   input  logic [NREQ*DW-1:0] Data,
   output logic [DW-1:0]     R,
   output logic [NREQ-1:0]   Gnt,
   output logic [NREQ-1:0]   Ack,
   output logic [IW-1:0]     Owner,
   output logic              Busy
);

   localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYC - 1);

   state_t          state_r;
   logic [IW-1:0]   win_r;
   logic [IW-1:0]   ptr_r;
   logic [3:0]      cnt_r;
   logic [DW-1:0]   r_r;
   logic [NREQ-1:0] gnt_r;
   logic [NREQ-1:0] ack_r;
   logic [IW-1:0]   owner_r;
   logic            busy_r;

   logic [IW-1:0]   pick_win_s;
   logic            pick_vld_s;
   logic [DW-1:0]   data_sel_s;

   rr_pick4 u_pick (
      .req (Req),
      .ptr (ptr_r),
      .win (pick_win_s),
      .vld (pick_vld_s)
   );

   // Data slice of the latched winner, sampled only at the GRANT closing edge.
   always_comb begin
      data_sel_s = {DW{1'b0}};
      case (win_r)
         2'd0:    data_sel_s = Data[15:0];
         2'd1:    data_sel_s = Data[31:16];
         2'd2:    data_sel_s = Data[47:32];
         2'd3:    data_sel_s = Data[63:48];
         default: data_sel_s = {DW{1'b0}};
      endcase
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state_r <= ST_IDLE;
         win_r   <= {IW{1'b0}};
         ptr_r   <= {IW{1'b0}};
         cnt_r   <= 4'd0;
         r_r     <= {DW{1'b0}};
         gnt_r   <= {NREQ{1'b0}};
         ack_r   <= {NREQ{1'b0}};
         owner_r <= {IW{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         ack_r <= {NREQ{1'b0}};
         case (state_r)
            ST_IDLE: begin
               if (pick_vld_s) begin
                  win_r   <= pick_win_s;
                  gnt_r   <= onehot4(pick_win_s);
                  busy_r  <= 1'b1;
                  state_r <= ST_GRANT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               gnt_r <= {NREQ{1'b0}};
               // A requester that dropped its line during GRANT aborts the write.
               if (Req[win_r]) begin
                  r_r     <= data_sel_s;
                  owner_r <= win_r;
                  ack_r   <= onehot4(win_r);
                  ptr_r   <= win_r + 2'd1;
                  cnt_r   <= CNT_LOAD;
                  state_r <= ST_HOLD;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (cnt_r == 4'd0) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            default: begin
               gnt_r   <= {NREQ{1'b0}};
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign R     = r_r;
   assign Gnt   = gnt_r;
   assign Ack   = ack_r;
   assign Owner = owner_r;
   assign Busy  = busy_r;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: a transaction model predicts grants,
// acks and register contents; a negedge monitor compares.
module tb_reg_share_arbiter;

   localparam int HOLD_CYC = 2;
`ifdef ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        Clk  = 1'b0;
   logic        Clrn = 1'b0;
   logic [3:0]  Req  = 4'b0;
   logic [63:0] Data = 64'b0;
   logic [15:0] R;
   logic [3:0]  Gnt;
   logic [3:0]  Ack;
   logic [1:0]  Owner;
   logic        Busy;

   always #5 Clk = ~Clk;

   reg_share_arbiter #(.HOLD_CYC(HOLD_CYC)) dut (
      .Clk(Clk), .Clrn(Clrn), .Req(Req), .Data(Data),
      .R(R), .Gnt(Gnt), .Ack(Ack), .Owner(Owner), .Busy(Busy)
   );

   typedef struct {
      logic [3:0]  ack;
      logic [15:0] r;
      logic [1:0]  owner;
   } ack_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [3:0]  gnt_q[$];
   ack_t        ack_q[$];
   int          ptr_m = 0;
   logic [15:0] model_r = 16'h0;
   logic [1:0]  model_owner = 2'd0;
   bit          exp_busy = 1'b0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      int start;
      start = RR_EN ? p : 0;
      for (int i = 0; i < 4; i++)
         if (r[(start + i) % 4]) return (start + i) % 4;
      return 0;
   endfunction

   function automatic logic [3:0] onehot(input int w);
      logic [3:0] o;
      o    = 4'b0;
      o[w] = 1'b1;
      return o;
   endfunction

   always @(negedge Clk) begin
      if (mon_en) begin
         chk("busy", {15'b0, Busy}, {15'b0, exp_busy});
         chk("r", R, model_r);
         chk("owner", {14'b0, Owner}, {14'b0, model_owner});
         if (Gnt !== 4'b0) begin
            if (gnt_q.size() == 0) chk("gnt_unexpected", {12'b0, Gnt}, 16'h0);
            else chk("gnt", {12'b0, Gnt}, {12'b0, gnt_q.pop_front()});
         end
         if (Ack !== 4'b0) begin
            if (ack_q.size() == 0) chk("ack_unexpected", {12'b0, Ack}, 16'h0);
            else begin
               ack_t e;
               e = ack_q.pop_front();
               chk("ack", {12'b0, Ack}, {12'b0, e.ack});
               chk("ack_r", R, e.r);
               chk("ack_owner", {14'b0, Owner}, {14'b0, e.owner});
            end
         end
      end
   end

   // One arbitration: grant at the next edge, then write (or abort) and hold.
   task automatic txn(input logic [3:0] req, input bit abort, input bit keep,
                      input logic [15:0] base);
      int w;
      logic [15:0] v;
      w = pick(req, ptr_m);
      Req  = req;
      Data = {$urandom, $urandom};
      gnt_q.push_back(onehot(w));
      @(posedge Clk); #2;
      exp_busy = 1'b1;
      if (abort) begin
         Req  = 4'b0;
         Data = {$urandom, $urandom};
         @(posedge Clk); #2;
         exp_busy = 1'b0;
      end else begin
         Data = {$urandom, $urandom};
         if (base != 16'h0)
            for (int i = 0; i < 4; i++) Data[16*i +: 16] = base + 16'(i);
         v = Data[16*w +: 16];
         ack_q.push_back('{onehot(w), v, 2'(w)});
         @(posedge Clk); #2;
         model_r     = v;
         model_owner = 2'(w);
         ptr_m       = (w + 1) % 4;
         if (!keep) Req = 4'b0;
         for (int i = 1; i <= HOLD_CYC; i++) begin
            Data = {$urandom, $urandom};
            @(posedge Clk); #2;
            if (i == HOLD_CYC) exp_busy = 1'b0;
         end
      end
   endtask

   initial begin
      int w;
      logic [15:0] v;
      repeat (2) @(posedge Clk);
      #2;
      Clrn   = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk); #2;
         chk("idle_gnt", {12'b0, Gnt}, 16'h0);
         chk("idle_ack", {12'b0, Ack}, 16'h0);
      end

      // Contention with all four requests held.
      for (int i = 0; i < 4; i++) txn(4'b1111, 1'b0, i != 3, 16'hA001);
      // Single write from requester 1.
      txn(4'b0010, 1'b0, 1'b0, 16'hBEEE);
      // Abort then re-request requester 2.
      txn(4'b0100, 1'b1, 1'b0, 16'h0);
      txn(4'b0100, 1'b0, 1'b0, 16'h0);

      for (int n = 0; n < 40; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            Data = {$urandom, $urandom};
            @(posedge Clk); #2;
         end
         txn(4'($urandom_range(1, 15)), ($urandom_range(0, 4) == 0), 1'b0, 16'h0);
      end

      // Reset while in HOLD.
      Req = 4'b0100;
      w = pick(Req, ptr_m);
      gnt_q.push_back(onehot(w));
      @(posedge Clk); #2;
      exp_busy = 1'b1;
      Data = {$urandom, $urandom};
      v = Data[16*w +: 16];
      ack_q.push_back('{onehot(w), v, 2'(w)});
      @(posedge Clk); #2;
      model_r = v; model_owner = 2'(w); ptr_m = (w + 1) % 4;
      Req = 4'b0;
      @(posedge Clk); #2;
      Clrn = 1'b0;
      model_r = 16'h0; model_owner = 2'd0; exp_busy = 1'b0; ptr_m = 0;
      repeat (2) @(posedge Clk);
      #2;
      Clrn = 1'b1;
      txn(4'b1010, 1'b0, 1'b0, 16'h0);
      txn(4'b1000, 1'b0, 1'b0, 16'h0);

      repeat (3) @(posedge Clk);
      #2;
      chk("gnt_left", 16'(gnt_q.size()), 16'h0);
      chk("ack_left", 16'(ack_q.size()), 16'h0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
